iic_wr_sched: RTL and testbench

IIC_WR_SCHED -- requirements
Module: iic_wr_sched

---
 rtl/iic_wr_sched.sv | 156 +++++++++++++++
 tb/tb_iic_wr_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_wr_sched.sv
// Two-requester IIC register-write scheduler: round-robin grant, then one byte-serial write.
// States: IDLE arbitrate | DEV addr+W, START | REGH/REGL register address | DATA payload, STOP | DRAIN wait tx idle
module iic_wr_sched #(
    parameter int ADDR_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [6:0]  req0_dev,
    input  logic [15:0] req0_reg,
    input  logic [7:0]  req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [6:0]  req1_dev,
    input  logic [15:0] req1_reg,
    input  logic [7:0]  req1_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        tx_stop,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        grant_id,
    output logic        done,
    output logic [15:0] xfer_count
);

    typedef enum logic [2:0] {IDLE, DEV, REGH, REGL, DATA, DRAIN} state_t;

    state_t      state_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        tx_stop_q;
    logic        busy_q;
    logic        grant_q;
    logic [15:0] reg_q;
    logic [7:0]  data_q;
    logic [15:0] count_q;
    logic [15:0] count_d;

    logic        take;
    logic        pick1;
    logic        accept;
    logic        drain_done;
    logic [6:0]  sel_dev;
    logic [15:0] sel_reg;
    logic [7:0]  sel_data;

    always_comb begin
        take       = tx_valid_q && tx_ready;
        // grant_q==0 means requester 0 went last, so requester 1 wins a tie
        pick1      = req1_valid && (!req0_valid || !grant_q);
        accept     = (state_q == IDLE) && (req0_valid || req1_valid);
        drain_done = (state_q == DRAIN) && tx_ready;
        count_d    = drain_done ? count_q + 16'd1 : count_q;
        sel_dev    = pick1 ? req1_dev  : req0_dev;
        sel_reg    = pick1 ? req1_reg  : req0_reg;
        sel_data   = pick1 ? req1_data : req0_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tx_stop_q  <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= 1'b1;
            reg_q      <= '0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_q    <= pick1;
                        busy_q     <= 1'b1;
                        reg_q      <= sel_reg;
                        data_q     <= sel_data;
                        tx_data_q  <= {sel_dev, 1'b0};
                        tx_start_q <= 1'b1;
                        tx_stop_q  <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= DEV;
                    end
                end
                DEV: begin
                    if (take) begin
                        tx_valid_q <= 1'b0;
                        tx_start_q <= 1'b0;
                        if (ADDR_BYTES == 2) begin
                            state_q   <= REGH;
                            tx_data_q <= reg_q[15:8];
                        end else begin
                            state_q   <= REGL;
                            tx_data_q <= reg_q[7:0];
                        end
                    end else begin
                        tx_valid_q <= 1'b1;
                    end
                end
                REGH: begin
                    if (take) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= reg_q[7:0];
                        state_q    <= REGL;
                    end else begin
                        tx_valid_q <= 1'b1;
                    end
                end
                REGL: begin
                    if (take) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= data_q;
                        tx_stop_q  <= 1'b1;
                        state_q    <= DATA;
                    end else begin
                        tx_valid_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (take) begin
                        tx_valid_q <= 1'b0;
                        tx_stop_q  <= 1'b0;
                        state_q    <= DRAIN;
                    end else begin
                        tx_valid_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (tx_ready) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = rst_n && accept && !pick1;
    assign req1_ready = rst_n && accept && pick1;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign tx_stop    = tx_stop_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign done       = drain_done;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_iic_wr_sched.sv
// Bench for iic_wr_sched: one instance per address width, each checked every cycle against a
// transaction-level model (expected byte list per write, take-driven pacing, round-robin grant).
module tb_iic_wr_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        r0v [2];
    logic        r0r [2];
    logic [6:0]  r0d [2];
    logic [15:0] r0g [2];
    logic [7:0]  r0t [2];
    logic        r1v [2];
    logic        r1r [2];
    logic [6:0]  r1d [2];
    logic [15:0] r1g [2];
    logic [7:0]  r1t [2];
    logic [7:0]  txd [2];
    logic        txs [2];
    logic        txp [2];
    logic        txv [2];
    logic        txr [2];
    logic        bsy [2];
    logic        gid [2];
    logic        dn  [2];
    logic [15:0] xc  [2];

    iic_wr_sched #(.ADDR_BYTES(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[0]), .req0_ready(r0r[0]), .req0_dev(r0d[0]), .req0_reg(r0g[0]), .req0_data(r0t[0]),
        .req1_valid(r1v[0]), .req1_ready(r1r[0]), .req1_dev(r1d[0]), .req1_reg(r1g[0]), .req1_data(r1t[0]),
        .tx_data(txd[0]), .tx_start(txs[0]), .tx_stop(txp[0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
        .busy(bsy[0]), .grant_id(gid[0]), .done(dn[0]), .xfer_count(xc[0])
    );

    iic_wr_sched #(.ADDR_BYTES(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[1]), .req0_ready(r0r[1]), .req0_dev(r0d[1]), .req0_reg(r0g[1]), .req0_data(r0t[1]),
        .req1_valid(r1v[1]), .req1_ready(r1r[1]), .req1_dev(r1d[1]), .req1_reg(r1g[1]), .req1_data(r1t[1]),
        .tx_data(txd[1]), .tx_start(txs[1]), .tx_stop(txp[1]), .tx_valid(txv[1]), .tx_ready(txr[1]),
        .busy(bsy[1]), .grant_id(gid[1]), .done(dn[1]), .xfer_count(xc[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // transaction-level model state, one slot per instance
    bit          m_txn   [2];
    int          m_idx   [2];
    bit          m_tookp [2];
    bit          m_last  [2];
    logic [15:0] m_cnt   [2];
    logic [7:0]  m_b     [2][4];
    bit          m_s     [2][4];
    bit          m_p     [2][4];
    bit          m_acc0  [2];
    bit          m_acc1  [2];

    logic [9:0]  log_b    [2][$];
    int          g_log    [2][$];
    int          done_cnt [2];
    int          acc_cyc  [2];
    int          done_cyc [2];

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input int k);
        chk(k, "rst_tx_valid", txv[k], 0);
        chk(k, "rst_tx_start", txs[k], 0);
        chk(k, "rst_tx_stop", txp[k], 0);
        chk(k, "rst_tx_data", txd[k], 0);
        chk(k, "rst_busy", bsy[k], 0);
        chk(k, "rst_done", dn[k], 0);
        chk(k, "rst_ready0", r0r[k], 0);
        chk(k, "rst_ready1", r1r[k], 0);
        chk(k, "rst_count", xc[k], 0);
        chk(k, "rst_grant", gid[k], 1);
    endtask

    task automatic check_update(input int k);
        int ab;
        int nb;
        int j;
        bit any;
        bit w;
        bit e_valid;
        bit e_done;
        logic [6:0]  dv;
        logic [15:0] rg;
        logic [7:0]  dt;
        ab = k + 1;
        nb = ab + 2;
        m_acc0[k] = 1'b0;
        m_acc1[k] = 1'b0;
        if (!rst_n) begin
            chk_reset_vals(k);
            m_txn[k] = 1'b0;
            m_idx[k] = 0;
            m_tookp[k] = 1'b0;
            m_last[k] = 1'b1;
            m_cnt[k] = 16'h0000;
            return;
        end
        any = r0v[k] || r1v[k];
        if (r0v[k] && r1v[k]) w = !m_last[k];
        else                  w = r1v[k];
        e_valid = m_txn[k] && (m_idx[k] < nb) && !m_tookp[k];
        e_done  = m_txn[k] && (m_idx[k] == nb) && txr[k];

        chk(k, "ready0", r0r[k], !m_txn[k] && any && !w);
        chk(k, "ready1", r1r[k], !m_txn[k] && any && w);
        chk(k, "busy", bsy[k], m_txn[k]);
        chk(k, "grant_id", gid[k], m_last[k]);
        chk(k, "xfer_count", xc[k], m_cnt[k]);
        chk(k, "tx_valid", txv[k], e_valid);
        chk(k, "done", dn[k], e_done);
        if (e_valid) begin
            chk(k, "tx_data", txd[k], m_b[k][m_idx[k]]);
            chk(k, "tx_start", txs[k], m_s[k][m_idx[k]]);
            chk(k, "tx_stop", txp[k], m_p[k][m_idx[k]]);
        end

        if (txv[k] && txr[k]) log_b[k].push_back({txs[k], txp[k], txd[k]});
        if (dn[k]) begin
            done_cnt[k]++;
            done_cyc[k] = cyc;
        end
        if (r0r[k] || r1r[k]) begin
            g_log[k].push_back(r1r[k] ? 1 : 0);
            acc_cyc[k] = cyc;
        end

        if (e_valid && txr[k]) begin
            m_idx[k]++;
            m_tookp[k] = 1'b1;
        end else begin
            m_tookp[k] = 1'b0;
        end
        if (e_done) begin
            m_txn[k] = 1'b0;
            m_cnt[k] = m_cnt[k] + 16'd1;
        end else if (!m_txn[k] && any) begin
            dv = w ? r1d[k] : r0d[k];
            rg = w ? r1g[k] : r0g[k];
            dt = w ? r1t[k] : r0t[k];
            for (int i = 0; i < 4; i++) begin
                m_s[k][i] = 1'b0;
                m_p[k][i] = 1'b0;
            end
            m_b[k][0] = {dv, 1'b0};
            m_s[k][0] = 1'b1;
            j = 1;
            if (ab == 2) begin
                m_b[k][1] = rg[15:8];
                j = 2;
            end
            m_b[k][j] = rg[7:0];
            m_b[k][j+1] = dt;
            m_p[k][j+1] = 1'b1;
            m_txn[k] = 1'b1;
            m_idx[k] = 0;
            m_tookp[k] = 1'b0;
            m_last[k] = w;
            if (w) m_acc1[k] = 1'b1;
            else   m_acc0[k] = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) check_update(k);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int k);
        if (m_acc0[k] || !r0v[k]) begin
            r0v[k] = ($urandom_range(0, 3) == 0);
            r0d[k] = 7'($urandom);
            r0g[k] = 16'($urandom);
            r0t[k] = 8'($urandom);
        end
        if (m_acc1[k] || !r1v[k]) begin
            r1v[k] = ($urandom_range(0, 3) == 0);
            r1d[k] = 7'($urandom);
            r1g[k] = 16'($urandom);
            r1t[k] = 8'($urandom);
        end
        txr[k] = ($urandom_range(0, 4) != 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            r0v[k] = 0; r0d[k] = '0; r0g[k] = '0; r0t[k] = '0;
            r1v[k] = 0; r1d[k] = '0; r1g[k] = '0; r1t[k] = '0;
            txr[k] = 1;
            m_txn[k] = 0; m_idx[k] = 0; m_tookp[k] = 0; m_last[k] = 1; m_cnt[k] = 0;
            m_acc0[k] = 0; m_acc1[k] = 0;
            done_cnt[k] = 0; acc_cyc[k] = 0; done_cyc[k] = 0;
        end
        repeat (3) step();
        rst_n = 1'b1;

        // single write on the 1-byte-address instance, 2-byte-address write on the other
        r0v[0] = 1; r0d[0] = 7'h50; r0g[0] = 16'h0012; r0t[0] = 8'hA5;
        r1v[1] = 1; r1d[1] = 7'h68; r1g[1] = 16'h1234; r1t[1] = 8'h7F;
        step();
        r0v[0] = 0;
        r1v[1] = 0;
        repeat (12) step();
        chk(0, "w1_nbytes", log_b[0].size(), 3);
        if (log_b[0].size() == 3) begin
            chk(0, "w1_b0", log_b[0][0], 10'h2A0);
            chk(0, "w1_b1", log_b[0][1], 10'h012);
            chk(0, "w1_b2", log_b[0][2], 10'h1A5);
        end
        chk(0, "w1_dones", done_cnt[0], 1);
        chk(0, "w1_count", xc[0], 1);
        chk(0, "w1_latency", done_cyc[0] - acc_cyc[0], 6);
        chk(1, "w2_nbytes", log_b[1].size(), 4);
        if (log_b[1].size() == 4) begin
            chk(1, "w2_b0", log_b[1][0], 10'h2D0);
            chk(1, "w2_b1", log_b[1][1], 10'h012);
            chk(1, "w2_b2", log_b[1][2], 10'h034);
            chk(1, "w2_b3", log_b[1][3], 10'h17F);
        end
        chk(1, "w2_grant", gid[1], 1);
        chk(1, "w2_latency", done_cyc[1] - acc_cyc[1], 8);

        // simultaneous requests held valid after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        g_log[0].delete();
        r0v[0] = 1; r0d[0] = 7'h11; r0g[0] = 16'h0001; r0t[0] = 8'h01;
        r1v[0] = 1; r1d[0] = 7'h22; r1g[0] = 16'h0002; r1t[0] = 8'h02;
        for (int i = 0; i < 60 && g_log[0].size() < 3; i++) step();
        r0v[0] = 0;
        r1v[0] = 0;
        repeat (10) step();
        chk(0, "rr_grants", g_log[0].size(), 3);
        if (g_log[0].size() == 3) begin
            chk(0, "rr_first", g_log[0][0], 0);
            chk(0, "rr_second", g_log[0][1], 1);
            chk(0, "rr_third", g_log[0][2], 0);
        end

        // backpressure while the register byte is offered
        log_b[0].delete();
        r0v[0] = 1; r0d[0] = 7'h50; r0g[0] = 16'h0012; r0t[0] = 8'hA5;
        txr[0] = 1;
        step();
        r0v[0] = 0;
        for (int i = 0; i < 10 && !(log_b[0].size() == 1 && txv[0]); i++) step();
        chk(0, "bp_reached_regl", log_b[0].size(), 1);
        txr[0] = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk(0, "bp_valid_held", txv[0], 1);
            chk(0, "bp_data_held", txd[0], 8'h12);
        end
        txr[0] = 1;
        repeat (10) step();
        chk(0, "bp_nbytes", log_b[0].size(), 3);
        if (log_b[0].size() == 3) begin
            chk(0, "bp_b0", log_b[0][0], 10'h2A0);
            chk(0, "bp_b1", log_b[0][1], 10'h012);
            chk(0, "bp_b2", log_b[0][2], 10'h1A5);
        end

        // reset while the data byte is offered
        log_b[0].delete();
        done_cnt[0] = 0;
        r0v[0] = 1; r0d[0] = 7'h3C; r0g[0] = 16'h0077; r0t[0] = 8'h99;
        step();
        r0v[0] = 0;
        for (int i = 0; i < 10 && !(log_b[0].size() == 2 && txv[0]); i++) step();
        chk(0, "mr_reached_data", log_b[0].size(), 2);
        r1v[0] = 1; r1d[0] = 7'h2A; r1g[0] = 16'h0055; r1t[0] = 8'h3C;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        repeat (3) step();
        chk(0, "mr_no_done", done_cnt[0], 0);
        log_b[0].delete();
        rst_n = 1'b1;
        step();
        r1v[0] = 0;
        repeat (10) step();
        chk(0, "mr_nbytes", log_b[0].size(), 3);
        if (log_b[0].size() == 3) chk(0, "mr_start_byte", log_b[0][0], 10'h254);
        chk(0, "mr_dones", done_cnt[0], 1);

        // counter wrap on the 2-byte-address instance
        force dut1.count_q = 16'hFFFF;
        m_cnt[1] = 16'hFFFF;
        repeat (2) step();
        release dut1.count_q;
        step();
        chk(1, "wrap_preload", xc[1], 16'hFFFF);
        done_cnt[1] = 0;
        r0v[1] = 1; r0d[1] = 7'h01; r0g[1] = 16'hBEEF; r0t[1] = 8'h42;
        step();
        r0v[1] = 0;
        repeat (12) step();
        chk(1, "wrap_count", xc[1], 16'h0000);
        chk(1, "wrap_done", done_cnt[1], 1);

        // randomized traffic with random transmitter readiness
        for (int i = 0; i < 3000; i++) begin
            drive_rand(0);
            drive_rand(1);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            r0v[k] = 0;
            r1v[k] = 0;
            txr[k] = 1;
        end
        repeat (20) step();
        chk(0, "final_idle", bsy[0], 0);
        chk(1, "final_idle", bsy[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
